bomb_scheduler: RTL and testbench
=================================

Name: bomb_scheduler

Overview:
- Owns the 6 bomb slots of the stage.
- Arbitrates bomb-placement requests from player 1 and player 2, and runs each bomb's fuse and blast timers on the game tick.
- Serialises detonation events to the explosion/tile datapath.
- Exposes a combinational per-slot read port indexed by the controller's bomb_id while bombs are being drawn.

Parameters:
- FUSE_TICKS, 12, ticks from placement to detonation (1..15).
- BLAST_TICKS, 4, ticks a detonated slot stays in blast before it frees (1..15).
- MAX_PER_PLAYER, 3, maximum live bombs (armed or blast) per player (1..3).

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high; clears all state
- tick  in  1  one-cycle game-tick pulse (frame refresh)
- clear  in  1  synchronous clear of all slots (new stage)
- p1_place  in  1  P1 placement request (level, held until ack/nack)
- p1_col, p1_row  in  4, 4  P1 tile coordinate
- p2_place  in  1  P2 placement request
- p2_col, p2_row  in  4, 4  P2 tile coordinate
- p1_ack, p1_nack  out  1, 1  one-cycle grant/reject for P1
- p2_ack, p2_nack  out  1, 1  one-cycle grant/reject for P2
- p1_count, p2_count  out  2, 2  live bombs owned by each player
- rd_id  in  3  slot index to read
- rd_valid  out  1  slot rd_id is live (armed or blast)
- rd_exploding  out  1  slot rd_id is in blast
- rd_owner  out  1  0 = P1, 1 = P2
- rd_col, rd_row  out  4, 4  slot coordinate
- explode_valid  out  1  one-cycle detonation event
- explode_col, explode_row  out  4, 4  detonation coordinate, valid with explode_valid

Behaviour:
- Per-slot state is FREE, ARMED (fuse counter) or BLAST (blast counter), plus owner, col and row.
- Reset (async) and clear (sync) do the same thing, and clear has priority over every other event in its cycle:
  - all slots FREE, counts 0, pending detonation mask 0;
  - all ack/nack/explode outputs 0;
  - round-robin pointer set to favour P1.
- Placement arbitration:
  - At most one request is resolved per cycle. A request level seen at edge N gets exactly one ack or nack pulse, registered, in cycle N+1.
  - The request is then ignored until the requester drops it for at least one cycle. An edge-detect/served flag is kept per player.
  - If both players have new requests in the same cycle, the player not granted last wins. The other player is resolved in the next cycle against the updated state.
  - A request is rejected (nack) if any of these hold: the owner's count equals MAX_PER_PLAYER; no slot is FREE; any live slot has the same col/row.
  - Otherwise the request is granted (ack): the lowest-index FREE slot becomes ARMED with fuse = FUSE_TICKS, the owner and coordinates are stored, and the owner's count increments.
- Tick processing:
  - On a cycle with tick=1, each ARMED slot decrements its fuse.
  - A slot whose fuse is 1 goes to BLAST with blast = BLAST_TICKS and sets its bit in the pending mask.
  - A BLAST slot at 1 goes to FREE, and its owner's count decrements.
- Simultaneous grant and tick:
  - Allocation uses the pre-tick slot state, so a slot freed on this tick cannot be granted in the same cycle.
  - A newly granted slot is not decremented on its grant cycle.
  - If the same owner has a grant and a free in one cycle, that owner's count is unchanged.
- Detonation output:
  - Each cycle, the lowest-index pending bit is cleared, and explode_valid is pulsed with that slot's coordinates on the following cycle. A 6-way simultaneous detonation therefore takes 6 cycles.
  - Pending bits persist across ticks until emitted. Chain reactions belong to the datapath, not this block.
- Read port:
  - Purely combinational from rd_id.
  - For rd_id 6 or 7, every read output is 0.

Test Plan:
- Reset then P1 request at (3,5) → p1_ack one cycle later, rd_id=0 gives valid=1, owner=0, col/row 3/5, p1_count=1.
- After 12 ticks → slot 0 goes exploding, explode_valid pulses once with (3,5); after 4 more ticks → slot 0 is FREE and p1_count=0.
- P1 and P2 request in the same cycle at different tiles → P1 acked first (P2 acked next cycle, slot 1); repeat → P2 now wins first.
- P2 places 3 bombs, then a 4th → nack, count stays 3. Any player requests an occupied tile → nack. Fill all 6 slots → 7th request nacked.
- Place 3 bombs on the same cycle-aligned fuse → 3 consecutive explode_valid pulses in slot order. A grant coinciding with a free tick leaves the count correct.
- Assert clear mid-fuse, and separately pulse reset mid-detonation burst → all rd_valid 0, counts 0, no further explode_valid.

Source files
------------

// File: rtl/bomb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_scheduler
//  Description : Six-slot bomb table. Arbitrates placement requests from two
//                players, runs fuse/blast timers on the game tick, serialises
//                detonation events and offers a combinational slot read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module bomb_scheduler #(
  parameter int FUSE_TICKS     = 12,
  parameter int BLAST_TICKS    = 4,
  parameter int MAX_PER_PLAYER = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       clear,
  input  logic       p1_place,
  input  logic [3:0] p1_col,
  input  logic [3:0] p1_row,
  input  logic       p2_place,
  input  logic [3:0] p2_col,
  input  logic [3:0] p2_row,
  output logic       p1_ack,
  output logic       p1_nack,
  output logic       p2_ack,
  output logic       p2_nack,
  output logic [1:0] p1_count,
  output logic [1:0] p2_count,
  input  logic [2:0] rd_id,
  output logic       rd_valid,
  output logic       rd_exploding,
  output logic       rd_owner,
  output logic [3:0] rd_col,
  output logic [3:0] rd_row,
  output logic       explode_valid,
  output logic [3:0] explode_col,
  output logic [3:0] explode_row
);

  localparam int         NUM_SLOTS = 6;
  localparam logic [3:0] C_FUSE    = 4'(FUSE_TICKS);
  localparam logic [3:0] C_BLAST   = 4'(BLAST_TICKS);
  localparam logic [1:0] C_MAX_CNT = 2'(MAX_PER_PLAYER);

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_ARMED = 2'd1,
    SLOT_BLAST = 2'd2
  } slot_state_e;

  // Per-slot state
  slot_state_e st_q    [NUM_SLOTS];
  slot_state_e st_d    [NUM_SLOTS];
  logic [3:0]  tmr_q   [NUM_SLOTS];
  logic [3:0]  tmr_d   [NUM_SLOTS];
  logic        owner_q [NUM_SLOTS];
  logic        owner_d [NUM_SLOTS];
  logic [3:0]  col_q   [NUM_SLOTS];
  logic [3:0]  col_d   [NUM_SLOTS];
  logic [3:0]  row_q   [NUM_SLOTS];
  logic [3:0]  row_d   [NUM_SLOTS];

  // Shared state
  logic [5:0] pend_q, pend_d;
  logic [1:0] p1_cnt_q, p1_cnt_d;
  logic [1:0] p2_cnt_q, p2_cnt_d;
  logic       prio_p2_q, prio_p2_d;
  logic       p1_served_q, p1_served_d;
  logic       p2_served_q, p2_served_d;
  logic       p1_ack_q, p1_ack_d, p1_nack_q, p1_nack_d;
  logic       p2_ack_q, p2_ack_d, p2_nack_q, p2_nack_d;
  logic       expl_valid_q, expl_valid_d;
  logic [3:0] expl_col_q, expl_col_d;
  logic [3:0] expl_row_q, expl_row_d;

  // Combinational helpers
  logic       new1, new2, sel_p2, req_any, grant;
  logic       free_found, dup_hit, emit_found;
  logic [2:0] free_idx, emit_idx;
  logic [3:0] req_col, req_row;
  logic [1:0] req_cnt;
  logic [2:0] p1_freed, p2_freed;
  logic [2:0] p1_next, p2_next;

  // Next-state: arbitration, tick processing, detonation serialisation
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      st_d[i]    = st_q[i];
      tmr_d[i]   = tmr_q[i];
      owner_d[i] = owner_q[i];
      col_d[i]   = col_q[i];
      row_d[i]   = row_q[i];
    end
    pend_d       = pend_q;
    p1_cnt_d     = p1_cnt_q;
    p2_cnt_d     = p2_cnt_q;
    prio_p2_d    = prio_p2_q;
    p1_ack_d     = 1'b0;
    p1_nack_d    = 1'b0;
    p2_ack_d     = 1'b0;
    p2_nack_d    = 1'b0;
    expl_valid_d = 1'b0;
    expl_col_d   = 4'd0;
    expl_row_d   = 4'd0;
    p1_freed     = 3'd0;
    p2_freed     = 3'd0;
    p1_next      = {1'b0, p1_cnt_q};
    p2_next      = {1'b0, p2_cnt_q};

    // A held request is served once; the flag drops when the level drops
    p1_served_d = p1_place & p1_served_q;
    p2_served_d = p2_place & p2_served_q;

    new1    = p1_place & ~p1_served_q;
    new2    = p2_place & ~p2_served_q;
    sel_p2  = new2 & (~new1 | prio_p2_q);
    req_any = new1 | new2;
    req_col = sel_p2 ? p2_col : p1_col;
    req_row = sel_p2 ? p2_row : p1_row;
    req_cnt = sel_p2 ? p2_cnt_q : p1_cnt_q;

    // Allocation and collision checks look at pre-tick slot state only
    free_found = 1'b0;
    free_idx   = 3'd0;
    dup_hit    = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (st_q[i] == SLOT_FREE) begin
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = 3'(i);
        end
      end else if (col_q[i] == req_col && row_q[i] == req_row) begin
        dup_hit = 1'b1;
      end
    end
    grant = req_any & free_found & ~dup_hit & (req_cnt != C_MAX_CNT);

    emit_found = 1'b0;
    emit_idx   = 3'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (pend_q[i] && !emit_found) begin
        emit_found = 1'b1;
        emit_idx   = 3'(i);
      end
    end

    if (clear) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_d[i]  = SLOT_FREE;
        tmr_d[i] = 4'd0;
      end
      pend_d    = 6'd0;
      p1_cnt_d  = 2'd0;
      p2_cnt_d  = 2'd0;
      prio_p2_d = 1'b0;
    end else begin
      // Only a contested cycle moves the fairness pointer, towards the loser
      if (new1 && new2) begin
        prio_p2_d = ~sel_p2;
      end
      if (req_any) begin
        if (sel_p2) begin
          p2_ack_d    = grant;
          p2_nack_d   = ~grant;
          p2_served_d = 1'b1;
        end else begin
          p1_ack_d    = grant;
          p1_nack_d   = ~grant;
          p1_served_d = 1'b1;
        end
      end

      if (emit_found) begin
        expl_valid_d     = 1'b1;
        expl_col_d       = col_q[emit_idx];
        expl_row_d       = row_q[emit_idx];
        pend_d[emit_idx] = 1'b0;
      end

      if (tick) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          case (st_q[i])
            SLOT_ARMED: begin
              if (tmr_q[i] == 4'd1) begin
                st_d[i]   = SLOT_BLAST;
                tmr_d[i]  = C_BLAST;
                pend_d[i] = 1'b1;
              end else begin
                tmr_d[i] = tmr_q[i] - 4'd1;
              end
            end
            SLOT_BLAST: begin
              if (tmr_q[i] == 4'd1) begin
                st_d[i]  = SLOT_FREE;
                tmr_d[i] = 4'd0;
                if (owner_q[i]) p2_freed = p2_freed + 3'd1;
                else            p1_freed = p1_freed + 3'd1;
              end else begin
                tmr_d[i] = tmr_q[i] - 4'd1;
              end
            end
            default: ;
          endcase
        end
      end

      // Granted slot was FREE, so the tick loop above never touched it
      if (grant) begin
        st_d[free_idx]    = SLOT_ARMED;
        tmr_d[free_idx]   = C_FUSE;
        owner_d[free_idx] = sel_p2;
        col_d[free_idx]   = req_col;
        row_d[free_idx]   = req_row;
      end

      p1_next  = {1'b0, p1_cnt_q} + {2'b00, grant & ~sel_p2} - p1_freed;
      p2_next  = {1'b0, p2_cnt_q} + {2'b00, grant & sel_p2} - p2_freed;
      p1_cnt_d = p1_next[1:0];
      p2_cnt_d = p2_next[1:0];
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i]    <= SLOT_FREE;
        tmr_q[i]   <= 4'd0;
        owner_q[i] <= 1'b0;
        col_q[i]   <= 4'd0;
        row_q[i]   <= 4'd0;
      end
      pend_q       <= 6'd0;
      p1_cnt_q     <= 2'd0;
      p2_cnt_q     <= 2'd0;
      prio_p2_q    <= 1'b0;
      p1_served_q  <= 1'b0;
      p2_served_q  <= 1'b0;
      p1_ack_q     <= 1'b0;
      p1_nack_q    <= 1'b0;
      p2_ack_q     <= 1'b0;
      p2_nack_q    <= 1'b0;
      expl_valid_q <= 1'b0;
      expl_col_q   <= 4'd0;
      expl_row_q   <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i]    <= st_d[i];
        tmr_q[i]   <= tmr_d[i];
        owner_q[i] <= owner_d[i];
        col_q[i]   <= col_d[i];
        row_q[i]   <= row_d[i];
      end
      pend_q       <= pend_d;
      p1_cnt_q     <= p1_cnt_d;
      p2_cnt_q     <= p2_cnt_d;
      prio_p2_q    <= prio_p2_d;
      p1_served_q  <= p1_served_d;
      p2_served_q  <= p2_served_d;
      p1_ack_q     <= p1_ack_d;
      p1_nack_q    <= p1_nack_d;
      p2_ack_q     <= p2_ack_d;
      p2_nack_q    <= p2_nack_d;
      expl_valid_q <= expl_valid_d;
      expl_col_q   <= expl_col_d;
      expl_row_q   <= expl_row_d;
    end
  end

  // Read port: free slots and out-of-range ids read as all zeros
  always_comb begin
    rd_valid     = 1'b0;
    rd_exploding = 1'b0;
    rd_owner     = 1'b0;
    rd_col       = 4'd0;
    rd_row       = 4'd0;
    if (rd_id < 3'd6) begin
      if (st_q[rd_id] != SLOT_FREE) begin
        rd_valid     = 1'b1;
        rd_exploding = (st_q[rd_id] == SLOT_BLAST);
        rd_owner     = owner_q[rd_id];
        rd_col       = col_q[rd_id];
        rd_row       = row_q[rd_id];
      end
    end
  end

  assign p1_ack        = p1_ack_q;
  assign p1_nack       = p1_nack_q;
  assign p2_ack        = p2_ack_q;
  assign p2_nack       = p2_nack_q;
  assign p1_count      = p1_cnt_q;
  assign p2_count      = p2_cnt_q;
  assign explode_valid = expl_valid_q;
  assign explode_col   = expl_col_q;
  assign explode_row   = expl_row_q;

endmodule
`default_nettype wire

// File: tb/tb_bomb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bomb_scheduler
//  Description : Scoreboard bench for bomb_scheduler. A slot-table model
//                updated on each clock edge queues expected ack/nack and
//                detonation events; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bomb_scheduler;

  localparam int FUSE  = 12;
  localparam int BLAST = 4;
  localparam int MAXPP = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, clear = 1'b0;
  logic       p1_place = 1'b0, p2_place = 1'b0;
  logic [3:0] p1_col = '0, p1_row = '0, p2_col = '0, p2_row = '0;
  logic [2:0] rd_id = '0;
  logic       p1_ack, p1_nack, p2_ack, p2_nack;
  logic [1:0] p1_count, p2_count;
  logic       rd_valid, rd_exploding, rd_owner;
  logic [3:0] rd_col, rd_row;
  logic       explode_valid;
  logic [3:0] explode_col, explode_row;

  int n_checks = 0;
  int n_fail   = 0;

  bomb_scheduler #(.FUSE_TICKS(FUSE), .BLAST_TICKS(BLAST), .MAX_PER_PLAYER(MAXPP)) dut (
    .clock(clock), .reset(reset), .tick(tick), .clear(clear),
    .p1_place(p1_place), .p1_col(p1_col), .p1_row(p1_row),
    .p2_place(p2_place), .p2_col(p2_col), .p2_row(p2_row),
    .p1_ack(p1_ack), .p1_nack(p1_nack), .p2_ack(p2_ack), .p2_nack(p2_nack),
    .p1_count(p1_count), .p2_count(p2_count),
    .rd_id(rd_id), .rd_valid(rd_valid), .rd_exploding(rd_exploding),
    .rd_owner(rd_owner), .rd_col(rd_col), .rd_row(rd_row),
    .explode_valid(explode_valid), .explode_col(explode_col), .explode_row(explode_row)
  );

  always #10 clock = ~clock;

  // ---------------- reference model: slot table (0 free, 1 armed, 2 blast)
  int m_st [6];
  int m_tmr[6];
  int m_own[6];
  int m_col[6];
  int m_row[6];
  bit m_pend[6];
  bit m_srv1, m_srv2, m_prio2;
  bit q1[$];
  bit q2[$];
  int qx[$];

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_st[i] = 0; m_tmr[i] = 0; m_pend[i] = 0;
    end
    m_srv1 = 0; m_srv2 = 0; m_prio2 = 0;
    q1.delete(); q2.delete(); qx.delete();
  endtask

  function automatic int live_cnt(int o);
    int n = 0;
    for (int i = 0; i < 6; i++) if (m_st[i] != 0 && m_own[i] == o) n++;
    return n;
  endfunction

  task automatic model_step();
    int who, c, r, live, fidx, e;
    bit n1, n2, dup, ok;
    if (clear) begin
      for (int i = 0; i < 6; i++) begin m_st[i] = 0; m_pend[i] = 0; end
      m_prio2 = 0;
      if (!p1_place) m_srv1 = 0;
      if (!p2_place) m_srv2 = 0;
      return;
    end
    n1 = p1_place && !m_srv1;
    n2 = p2_place && !m_srv2;
    who = 0;
    if (n1 && n2) begin
      who = m_prio2 ? 2 : 1;
      m_prio2 = (who == 1);
    end else if (n1) who = 1;
    else if (n2) who = 2;
    ok = 0; fidx = -1; c = 0; r = 0;
    if (who != 0) begin
      c = (who == 1) ? int'(p1_col) : int'(p2_col);
      r = (who == 1) ? int'(p1_row) : int'(p2_row);
      live = live_cnt(who - 1);
      dup = 0;
      for (int i = 0; i < 6; i++) begin
        if (m_st[i] != 0) begin
          if (m_col[i] == c && m_row[i] == r) dup = 1;
        end else if (fidx < 0) fidx = i;
      end
      ok = (live < MAXPP) && (fidx >= 0) && !dup;
    end
    e = -1;
    for (int i = 5; i >= 0; i--) if (m_pend[i]) e = i;
    if (e >= 0) begin
      qx.push_back(m_col[e] * 16 + m_row[e]);
      m_pend[e] = 0;
    end
    if (tick) begin
      for (int i = 0; i < 6; i++) begin
        case (m_st[i])
          1: if (m_tmr[i] == 1) begin m_st[i] = 2; m_tmr[i] = BLAST; m_pend[i] = 1; end
             else m_tmr[i]--;
          2: if (m_tmr[i] == 1) m_st[i] = 0; else m_tmr[i]--;
          default: ;
        endcase
      end
    end
    if (ok) begin
      m_st[fidx] = 1; m_tmr[fidx] = FUSE; m_own[fidx] = who - 1;
      m_col[fidx] = c; m_row[fidx] = r;
    end
    if (who == 1) begin q1.push_back(ok); m_srv1 = 1; end
    if (who == 2) begin q2.push_back(ok); m_srv2 = 1; end
    if (!p1_place) m_srv1 = 0;
    if (!p2_place) m_srv2 = 0;
  endtask

  // Model advances on the same edges as the DUT
  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // ---------------- checking
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples away from the active edge, pops queued expectations
  initial begin
    int id, ev;
    bit exp_ok;
    forever begin
      @(negedge clock);
      rd_id = 3'($urandom_range(0, 7));
      #1;
      chk("p1_count", p1_count, live_cnt(0));
      chk("p2_count", p2_count, live_cnt(1));
      id = int'(rd_id);
      if (id < 6 && m_st[id] != 0) begin
        chk("rd_valid", rd_valid, 1);
        chk("rd_exploding", rd_exploding, m_st[id] == 2);
        chk("rd_owner", rd_owner, m_own[id]);
        chk("rd_col", rd_col, m_col[id]);
        chk("rd_row", rd_row, m_row[id]);
      end else begin
        chk("rd_idle", {rd_valid, rd_exploding, rd_owner, rd_col, rd_row}, 0);
      end
      if (p1_ack || p1_nack) begin
        if (q1.size() == 0) chk("p1_unexpected_resp", {p1_ack, p1_nack}, 0);
        else begin
          exp_ok = q1.pop_front();
          chk("p1_ack", p1_ack, exp_ok);
          chk("p1_nack", p1_nack, !exp_ok);
        end
      end
      chk("p1_resp_missing", q1.size(), 0);
      if (p2_ack || p2_nack) begin
        if (q2.size() == 0) chk("p2_unexpected_resp", {p2_ack, p2_nack}, 0);
        else begin
          exp_ok = q2.pop_front();
          chk("p2_ack", p2_ack, exp_ok);
          chk("p2_nack", p2_nack, !exp_ok);
        end
      end
      chk("p2_resp_missing", q2.size(), 0);
      if (explode_valid) begin
        if (qx.size() == 0) chk("explode_unexpected", explode_valid, 0);
        else begin
          ev = qx.pop_front();
          chk("explode_coord", {explode_col, explode_row}, ev);
        end
      end
      chk("explode_missing", qx.size(), 0);
    end
  end

  // ---------------- stimulus
  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic req(int p, int c, int r);
    if (p == 1) begin p1_place = 1'b1; p1_col = 4'(c); p1_row = 4'(r); end
    else        begin p2_place = 1'b1; p2_col = 4'(c); p2_row = 4'(r); end
  endtask

  task automatic rel(int p);
    if (p == 1) p1_place = 1'b0; else p2_place = 1'b0;
  endtask

  task automatic place(int p, int c, int r);
    req(p, c, r); cyc(2); rel(p); cyc(1);
  endtask

  task automatic both(int c1, int r1, int c2, int r2);
    req(1, c1, r1); req(2, c2, r2); cyc(3); rel(1); rel(2); cyc(1);
  endtask

  task automatic ticks(int n);
    repeat (n) begin tick = 1'b1; cyc(1); tick = 1'b0; cyc(1); end
  endtask

  initial begin
    model_reset();
    cyc(2);
    reset = 1'b0;
    cyc(2);
    // single bomb lifecycle
    place(1, 3, 5);
    ticks(16); cyc(8);
    // contention, then contention again with the other player favoured
    both(1, 1, 2, 2);
    both(1, 2, 2, 1);
    // per-player limit, occupied tile, full table
    place(2, 4, 4); place(2, 5, 5); place(1, 2, 2);
    place(1, 6, 6); place(1, 7, 7); place(2, 8, 8);
    ticks(12); cyc(8); ticks(4); cyc(4);
    // aligned fuses, reset in the middle of the detonation burst
    place(1, 1, 1); place(1, 1, 2); place(1, 1, 3);
    ticks(12); cyc(1);
    reset = 1'b1; cyc(1); reset = 1'b0; cyc(10);
    // clear mid-fuse
    place(2, 9, 9); place(1, 9, 8);
    ticks(5); clear = 1'b1; cyc(1); clear = 1'b0;
    ticks(10); cyc(8);
    // randomized traffic on a small tile range to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      if (p1_place) begin if ($urandom_range(0, 1) == 1) rel(1); end
      else if ($urandom_range(0, 2) == 0) req(1, $urandom_range(0, 3), $urandom_range(0, 3));
      if (p2_place) begin if ($urandom_range(0, 1) == 1) rel(2); end
      else if ($urandom_range(0, 2) == 0) req(2, $urandom_range(0, 3), $urandom_range(0, 3));
      tick  = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 399) == 0);
      reset = (i == 1500);
      cyc(1);
    end
    rel(1); rel(2); tick = 1'b0; clear = 1'b0; reset = 1'b0;
    cyc(40);
    chk("drain_p1", q1.size(), 0);
    chk("drain_p2", q2.size(), 0);
    chk("drain_explode", qx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
